// File: rtl/baud_tick_generator_pkg.sv
// rtl/baud_tick_generator_pkg.sv - shared UART constants and the clog2 helper
package baud_tick_generator_pkg;

  // Defaults shared with the UART RX/TX blocks so every block agrees on timing.
  localparam int DEFAULT_CLOCK_FREQ    = 100_000_000;
  localparam int DEFAULT_BAUD          = 9600;
  localparam int DEFAULT_SAMPLING_RATE = 16;
  localparam int DEFAULT_BAUD_WIDTH    = 20;

  // Ceiling log2 usable in constant expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/baud_tick_generator_if.sv
// rtl/baud_tick_generator_if.sv - enable, config handshake and tick outputs of the baud generator
interface baud_tick_generator_if
  import baud_tick_generator_pkg::*;
#(
  parameter int BAUD_WIDTH = DEFAULT_BAUD_WIDTH,
  parameter int IDX_WIDTH  = clog2(DEFAULT_SAMPLING_RATE)
);

  logic                  enable;
  logic                  cfg_load;
  logic [BAUD_WIDTH-1:0] cfg_baud;
  logic                  cfg_ack;
  logic                  cfg_err;
  logic [BAUD_WIDTH-1:0] active_baud;
  logic                  sample_tick;
  logic                  bit_tick;
  logic [IDX_WIDTH-1:0]  sample_idx;

  // The consumer that requests rates and uses the ticks.
  modport master (
    output enable, cfg_load, cfg_baud,
    input  cfg_ack, cfg_err, active_baud, sample_tick, bit_tick, sample_idx
  );

  // The generator itself.
  modport slave (
    input  enable, cfg_load, cfg_baud,
    output cfg_ack, cfg_err, active_baud, sample_tick, bit_tick, sample_idx
  );

endinterface

// File: rtl/baud_tick_generator_sample_counter.sv
// rtl/baud_tick_generator_sample_counter.sv - sample index within a bit and bit-wrap pulse
module baud_tick_generator_sample_counter
  import baud_tick_generator_pkg::*;
#(
  parameter int SAMPLING_RATE = DEFAULT_SAMPLING_RATE,
  parameter int IDX_W         = clog2(SAMPLING_RATE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick_in,
  output logic [IDX_W-1:0] sample_idx,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLING_RATE - 1);

  // tick_in is the pre-register tick, so index and wrap line up with the registered sample_tick.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_idx <= '0;
      wrap       <= 1'b0;
    end else if (tick_in) begin
      wrap       <= (sample_idx == LAST_IDX);
      sample_idx <= (sample_idx == LAST_IDX) ? '0 : sample_idx + IDX_W'(1);
    end else begin
      wrap       <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_tick_generator.sv
// rtl/baud_tick_generator.sv - fractional-accumulator baud and oversampling tick generator
module baud_tick_generator
  import baud_tick_generator_pkg::*;
#(
  parameter int CLOCK_FREQ    = DEFAULT_CLOCK_FREQ,
  parameter int BAUD_RATE     = DEFAULT_BAUD,
  parameter int SAMPLING_RATE = DEFAULT_SAMPLING_RATE,
  parameter int BAUD_WIDTH    = DEFAULT_BAUD_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  baud_tick_generator_if.slave bus
);

  localparam int IDX_W  = clog2(SAMPLING_RATE);
  localparam int ACC_W  = clog2(CLOCK_FREQ + CLOCK_FREQ / 2) + 1;
  // Wide enough for baud*rate and acc+step without any wraparound.
  localparam int CALC_W = BAUD_WIDTH + IDX_W + ACC_W + 2;

  localparam logic [CALC_W-1:0] FREQ_C = CALC_W'(CLOCK_FREQ);
  localparam logic [CALC_W-1:0] HALF_C = CALC_W'(CLOCK_FREQ / 2);
  localparam logic [CALC_W-1:0] RATE_C = CALC_W'(SAMPLING_RATE);

  // A rate above half the clock would allow back-to-back ticks; odd rates break the mid-bit sample.
  if (SAMPLING_RATE < 2 || (SAMPLING_RATE % 2) != 0) begin : g_bad_rate
    $fatal(1, "baud_tick_generator: SAMPLING_RATE must be an even integer >= 2");
  end
  if (64'(BAUD_RATE) * 64'(SAMPLING_RATE) > 64'(CLOCK_FREQ / 2)) begin : g_bad_baud
    $fatal(1, "baud_tick_generator: BAUD_RATE*SAMPLING_RATE exceeds CLOCK_FREQ/2");
  end

  logic [ACC_W-1:0]      acc;
  logic [BAUD_WIDTH-1:0] active_baud;
  logic                  sample_tick;
  logic                  cfg_ack;
  logic                  cfg_err;
  logic [CALC_W-1:0]     step;
  logic [CALC_W-1:0]     sum;
  logic [CALC_W-1:0]     cfg_step;
  logic                  cfg_ok;
  logic                  accept;
  logic                  tick_next;
  logic [IDX_W-1:0]      sample_idx;
  logic                  wrap;

  // Step, next accumulator value, request validation and the would-be tick.
  always_comb begin
    step      = CALC_W'(active_baud) * RATE_C;
    sum       = CALC_W'(acc) + step;
    cfg_step  = CALC_W'(bus.cfg_baud) * RATE_C;
    cfg_ok    = (bus.cfg_baud != '0) && (cfg_step <= HALF_C);
    accept    = bus.cfg_load && cfg_ok;
    // An accepted load restarts phase, so a coinciding tick is dropped.
    tick_next = bus.enable && !accept && (sum >= FREQ_C);
  end

  // Accumulator, active rate, registered tick and the one-cycle handshake responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      active_baud <= BAUD_WIDTH'(BAUD_RATE);
      sample_tick <= 1'b0;
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_ack <= bus.cfg_load && cfg_ok;
      cfg_err <= bus.cfg_load && !cfg_ok;
      if (accept) begin
        active_baud <= bus.cfg_baud;
        acc         <= '0;
        sample_tick <= 1'b0;
      end else if (bus.enable) begin
        // After a tick the remainder is below step, which fits in ACC_W bits.
        acc         <= tick_next ? ACC_W'(sum - FREQ_C) : ACC_W'(sum);
        sample_tick <= tick_next;
      end else begin
        sample_tick <= 1'b0;
      end
    end
  end

  baud_tick_generator_sample_counter #(
    .SAMPLING_RATE(SAMPLING_RATE),
    .IDX_W        (IDX_W)
  ) u_sample_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .tick_in   (tick_next),
    .sample_idx(sample_idx),
    .wrap      (wrap)
  );

  assign bus.cfg_ack     = cfg_ack;
  assign bus.cfg_err     = cfg_err;
  assign bus.active_baud = active_baud;
  assign bus.sample_tick = sample_tick;
  assign bus.bit_tick    = wrap;
  assign bus.sample_idx  = sample_idx;

endmodule

// File: tb/tb_baud_tick_generator.sv
// tb/tb_baud_tick_generator.sv - directed bench for baud_tick_generator
module tb_baud_tick_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   compared   = 0;
  int   mismatched = 0;

  baud_tick_generator_if #(.BAUD_WIDTH(20), .IDX_WIDTH(2)) bus_a ();
  baud_tick_generator_if #(.BAUD_WIDTH(20), .IDX_WIDTH(2)) bus_b ();

  baud_tick_generator #(
    .CLOCK_FREQ(1000), .BAUD_RATE(10), .SAMPLING_RATE(4), .BAUD_WIDTH(20)
  ) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );

  baud_tick_generator #(
    .CLOCK_FREQ(100), .BAUD_RATE(3), .SAMPLING_RATE(4), .BAUD_WIDTH(20)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a          = 1'b1;
    bus_a.enable   = 1'b1;
    bus_a.cfg_load = 1'b0;
    bus_a.cfg_baud = '0;
    step_clk();
    step_clk();
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst_a          = 1'b1;
    bus_a.enable   = 1'b1;
    bus_a.cfg_load = 1'b1;
    bus_a.cfg_baud = 20'd20;
    step_clk();
    step_clk();
    got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
    compared++;
    if (got !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b expected 000000", got);
    end
    compared++;
    if (bus_a.active_baud !== 20'd10) begin
      mismatched++;
      $display("FAIL reset_active_baud: got %0d expected 10", bus_a.active_baud);
    end
    bus_a.cfg_load = 1'b0;
  endtask

  task automatic test_basic_rate();
    logic [5:0] got;
    logic [5:0] exp;
    reset_a();
    for (int n = 1; n <= 200; n++) begin
      step_clk();
      exp = {2'b00, 1'(n % 25 == 0), 1'(n % 100 == 0), 2'((n / 25) % 4)};
      got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL basic_rate edge %0d: got %b expected %b", n, got, exp);
      end
    end
  endtask

  task automatic test_fractional();
    int gaps[3] = '{9, 8, 8};
    int g = 0;
    int next_tick = 9;
    int ticks = 0;
    logic [3:0] got;
    logic [3:0] exp;
    logic et;
    rst_b          = 1'b1;
    bus_b.enable   = 1'b1;
    bus_b.cfg_load = 1'b0;
    bus_b.cfg_baud = '0;
    step_clk();
    rst_b = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      step_clk();
      et = (n == next_tick);
      if (et) begin
        ticks++;
        g = (g + 1) % 3;
        next_tick = next_tick + gaps[g];
      end
      exp = {et, 1'(et && (ticks % 4 == 0)), 2'(ticks % 4)};
      got = {bus_b.sample_tick, bus_b.bit_tick, bus_b.sample_idx};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL fractional edge %0d: got %b expected %b", n, got, exp);
      end
    end
    compared++;
    if (ticks != 12 || next_tick != 109) begin
      mismatched++;
      $display("FAIL fractional_count: got %0d ticks expected 12", ticks);
    end
  endtask

  task automatic test_pause();
    logic [3:0] got;
    logic [3:0] exp;
    reset_a();
    repeat (30) step_clk();
    compared++;
    if (bus_a.sample_idx !== 2'd1) begin
      mismatched++;
      $display("FAIL pause_pre_idx: got %0d expected 1", bus_a.sample_idx);
    end
    bus_a.enable = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      step_clk();
      got = {bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
      compared++;
      if (got !== 4'b0001) begin
        mismatched++;
        $display("FAIL pause_hold edge %0d: got %b expected 0001", n, got);
      end
    end
    bus_a.enable = 1'b1;
    for (int m = 1; m <= 20; m++) begin
      step_clk();
      exp = (m == 20) ? 4'b1010 : 4'b0001;
      got = {bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL pause_resume edge %0d: got %b expected %b", m, got, exp);
      end
    end
  endtask

  task automatic test_cfg_accept();
    logic [5:0] got;
    logic [5:0] exp;
    int ticks = 0;
    logic et;
    reset_a();
    repeat (49) step_clk();
    bus_a.cfg_load = 1'b1;
    bus_a.cfg_baud = 20'd20;
    step_clk();
    bus_a.cfg_load = 1'b0;
    got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
    compared++;
    if (got !== 6'b100000) begin
      mismatched++;
      $display("FAIL accept_response: got %b expected 100000", got);
    end
    compared++;
    if (bus_a.active_baud !== 20'd20) begin
      mismatched++;
      $display("FAIL accept_active_baud: got %0d expected 20", bus_a.active_baud);
    end
    for (int m = 1; m <= 50; m++) begin
      step_clk();
      et = (m == 13 || m == 25 || m == 38 || m == 50);
      if (et) ticks++;
      exp = {2'b00, et, 1'(m == 50), 2'(ticks % 4)};
      got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL accept_cadence edge %0d: got %b expected %b", m, got, exp);
      end
    end
  endtask

  task automatic test_cfg_reject();
    logic [5:0] got;
    logic [5:0] exp;
    reset_a();
    repeat (10) step_clk();
    bus_a.cfg_load = 1'b1;
    bus_a.cfg_baud = 20'd0;
    step_clk();
    got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
    compared++;
    if (got !== 6'b010000 || bus_a.active_baud !== 20'd10) begin
      mismatched++;
      $display("FAIL reject_zero: got %b baud %0d expected 010000 baud 10", got, bus_a.active_baud);
    end
    bus_a.cfg_baud = 20'd200;
    step_clk();
    bus_a.cfg_load = 1'b0;
    got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
    compared++;
    if (got !== 6'b010000 || bus_a.active_baud !== 20'd10) begin
      mismatched++;
      $display("FAIL reject_fast: got %b baud %0d expected 010000 baud 10", got, bus_a.active_baud);
    end
    for (int n = 13; n <= 100; n++) begin
      step_clk();
      exp = {2'b00, 1'(n % 25 == 0), 1'(n % 100 == 0), 2'((n / 25) % 4)};
      got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL reject_cadence edge %0d: got %b expected %b", n, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got;
    logic [5:0] exp;
    reset_a();
    repeat (5) step_clk();
    bus_a.cfg_load = 1'b1;
    bus_a.cfg_baud = 20'd126;
    step_clk();
    got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
    compared++;
    if (got !== 6'b010000 || bus_a.active_baud !== 20'd10) begin
      mismatched++;
      $display("FAIL b2b_reject_126: got %b baud %0d expected 010000 baud 10", got, bus_a.active_baud);
    end
    bus_a.enable   = 1'b0;
    bus_a.cfg_baud = 20'd125;
    step_clk();
    bus_a.cfg_load = 1'b0;
    bus_a.enable   = 1'b1;
    got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
    compared++;
    if (got !== 6'b100000 || bus_a.active_baud !== 20'd125) begin
      mismatched++;
      $display("FAIL b2b_accept_125: got %b baud %0d expected 100000 baud 125", got, bus_a.active_baud);
    end
    for (int m = 1; m <= 8; m++) begin
      step_clk();
      exp = {2'b00, 1'(m % 2 == 0), 1'(m == 8), 2'((m / 2) % 4)};
      got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL b2b_max_rate edge %0d: got %b expected %b", m, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] got;
    logic [5:0] exp;
    reset_a();
    repeat (5) step_clk();
    bus_a.cfg_load = 1'b1;
    bus_a.cfg_baud = 20'd20;
    step_clk();
    bus_a.cfg_load = 1'b0;
    repeat (30) step_clk();
    compared++;
    if (bus_a.sample_idx !== 2'd2 || bus_a.active_baud !== 20'd20) begin
      mismatched++;
      $display("FAIL midreset_pre: got idx %0d baud %0d expected idx 2 baud 20", bus_a.sample_idx, bus_a.active_baud);
    end
    rst_a          = 1'b1;
    bus_a.cfg_load = 1'b1;
    step_clk();
    got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
    compared++;
    if (got !== 6'b0 || bus_a.active_baud !== 20'd10) begin
      mismatched++;
      $display("FAIL midreset_state: got %b baud %0d expected 000000 baud 10", got, bus_a.active_baud);
    end
    rst_a          = 1'b0;
    bus_a.cfg_load = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      step_clk();
      exp = {2'b00, 1'(n == 25), 1'b0, 2'(n >= 25 ? 1 : 0)};
      got = {bus_a.cfg_ack, bus_a.cfg_err, bus_a.sample_tick, bus_a.bit_tick, bus_a.sample_idx};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL midreset_restart edge %0d: got %b expected %b", n, got, exp);
      end
    end
  endtask

  initial begin
    rst_a          = 1'b1;
    rst_b          = 1'b1;
    bus_a.enable   = 1'b0;
    bus_a.cfg_load = 1'b0;
    bus_a.cfg_baud = '0;
    bus_b.enable   = 1'b0;
    bus_b.cfg_load = 1'b0;
    bus_b.cfg_baud = '0;
    test_reset();
    test_basic_rate();
    test_fractional();
    test_pause();
    test_cfg_accept();
    test_cfg_reject();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/baud_tick_generator.md
Name: baud_tick_generator

Overview:
- Parametrised, runtime-reconfigurable successor to the fixed-divisor baud clock.
- Produces one-cycle sample_tick pulses at BAUD*SAMPLING_RATE and bit_tick pulses once per bit, using a fractional (Bresenham) accumulator. The long-run rate is therefore exact, and each interval is within one clock of ideal.
- Baud rate can be changed at runtime through a load/ack/err handshake.
- Feeds the UART RX oversampler (sample_tick, sample_idx) and the UART TX bit timer (bit_tick).

Parameters:
- CLOCK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, baud rate in effect after reset.
- SAMPLING_RATE, 16, sample ticks per bit; must be an even integer, at least 2.
- BAUD_WIDTH, 20, width of cfg_baud and active_baud.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when high, the accumulator advances; when low, it and the sample counter hold.
- cfg_load  in  1  one-cycle strobe requesting a new baud rate.
- cfg_baud  in  BAUD_WIDTH  requested baud rate in Hz; sampled when cfg_load is high.
- cfg_ack  out  1  one-cycle pulse: the request was accepted.
- cfg_err  out  1  one-cycle pulse: the request was rejected.
- active_baud  out  BAUD_WIDTH  baud rate currently in effect.
- sample_tick  out  1  one-cycle pulse at the oversampling rate.
- bit_tick  out  1  one-cycle pulse once every SAMPLING_RATE sample ticks.
- sample_idx  out  clog2(SAMPLING_RATE)  index of the current sample within the bit, 0..SAMPLING_RATE-1.

Behaviour:
- Reset (rst high at a clock edge) forces: acc=0, sample_idx=0, sample_tick=0, bit_tick=0, cfg_ack=0, cfg_err=0, active_baud=BAUD_RATE.
  - rst has priority over every other input.
  - Reset mid-operation discards any runtime baud and restarts phase from zero.
- Step and accumulator:
  - step = active_baud*SAMPLING_RATE, computed combinationally.
  - acc width = clog2(CLOCK_FREQ + CLOCK_FREQ/2)+1, so there is no overflow.
- Each edge with enable=1 and no accepted load:
  - If acc+step >= CLOCK_FREQ: acc <= acc+step-CLOCK_FREQ and sample_tick <= 1.
  - Otherwise: acc <= acc+step and sample_tick <= 0.
- sample_tick is registered: it is high for exactly one cycle and is never high on two consecutive cycles, because step <= CLOCK_FREQ/2.
- Sample index and bit tick:
  - On each sample tick, sample_idx increments, wrapping from SAMPLING_RATE-1 to 0.
  - bit_tick is high in the same cycle as the sample_tick at which sample_idx wraps to 0.
  - sample_idx changes in the same cycle that sample_tick is high, and shows the new index.
- enable=0: acc and sample_idx hold; sample_tick=0 and bit_tick=0 from the next edge.
- Config handshake, on an edge with cfg_load=1:
  - Reject if cfg_baud==0 or cfg_baud*SAMPLING_RATE > CLOCK_FREQ/2. Result: cfg_err=1 for one cycle; active_baud, acc and sample_idx are unchanged.
  - Otherwise accept. Result: active_baud <= cfg_baud, acc <= 0, sample_idx <= 0, sample_tick and bit_tick forced 0 that cycle, cfg_ack=1 for one cycle.
  - A load is processed regardless of enable.
  - An accepted load that coincides with a would-be tick takes priority; that tick is lost.
  - Back-to-back loads: each load is answered independently on the following cycle.
- Elaboration checks: if the BAUD_RATE*SAMPLING_RATE > CLOCK_FREQ/2 constraint fails, or SAMPLING_RATE is odd, elaboration stops with a fatal error.
- Timing: average interval between sample ticks = CLOCK_FREQ/step clocks; every individual interval is floor or ceil of that value.

Decomposition:
- Shared uart package/header holds:
  - the clog2 constant function;
  - defaults DEFAULT_CLOCK_FREQ, DEFAULT_BAUD, DEFAULT_SAMPLING_RATE, used by RX/TX too.
- One sub-module is natural: sample_counter (parameter SAMPLING_RATE).
  - Inputs: clk, rst, clear, tick_in.
  - Outputs: sample_idx, wrap.
  - The top keeps the accumulator and handshake logic.

Test Plan:
- CLOCK_FREQ=1000, BAUD_RATE=10, SAMPLING_RATE=4; release reset, enable=1 -> sample_tick every 25 clocks exactly (first tick on the 25th edge after reset); bit_tick every 100 clocks; sample_idx cycles 1,2,3,0.
- CLOCK_FREQ=100, BAUD_RATE=3, SAMPLING_RATE=4 -> tick intervals repeat 9,8,8; exactly 12 ticks per 100 enabled clocks.
- Using the first configuration: enable low for 40 cycles mid-interval -> no ticks; after re-enable, the next tick lands 25 minus pre-pause enabled cycles later; sample_idx is unchanged across the pause.
- cfg_load with cfg_baud=20 (first configuration) -> cfg_ack the next cycle; active_baud=20; acc and idx cleared; ticks every 12 or 13 clocks (12.5 average).
- cfg_load with cfg_baud=0, then with cfg_baud=200 (200*4 > 500) -> cfg_err for each; active_baud stays 10; tick cadence is undisturbed.
- Assert rst mid-bit after a runtime change to 20 -> all outputs 0; active_baud=10; first tick 25 clocks after release.
